float_add_pipe: RTL and testbench
=================================

# float_add_pipe

Parametrised, pipelined IEEE-754-style floating-point adder/subtractor with a valid/ready stream interface. It is the clocked successor to the combinational single-precision adder. Exponent and mantissa widths are configurable, and it adds a subtract mode, round-to-nearest-even, and exception flags. It sits in the convolution datapath between the multiplier array and the partial-sum accumulators. It sustains one operation per clock when not back-pressured.

## Interface
- EXP_W, 8: exponent field width (≥3).
- MAN_W, 23: stored mantissa (fraction) width (≥2). Word width W = 1+EXP_W+MAN_W (derived localparam, default 32).
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts operands this cycle.
- a  in  W  operand A (sign, exponent, fraction).
- b  in  W  operand B.
- sub  in  1  1: compute a−b (sign of b inverted at stage 1); 0: a+b.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- sum  out  W  result.
- ovf  out  1  result overflowed to infinity (finite inputs only).
- inv  out  1  invalid operation (NaN input or ∞−∞); sum is canonical qNaN.

## Operation
- Four stages, each with its own valid bit:
  - **S1 unpack:** apply sub; classify zero/∞/NaN; denormal inputs flush to signed zero; prepend hidden 1; swap so the larger magnitude is operand X.
  - **S2 align:** right-shift Y by exponent difference into MAN_W+4 bits (guard, round, sticky). Shifts ≥ MAN_W+3 leave only sticky = OR of Y.
  - **S3 add:** add or subtract magnitudes per effective sign; result sign = sign of X.
  - **S4 normalise/round/pack:**
    - Leading-zero normalise, or 1-bit right shift on carry-out.
    - Round to nearest, ties to even; rounding carry renormalises.
    - Pack result.
- Specials, decided in S1 and carried as bypass:
  - Any NaN input, or ∞ + (−∞) after sub is applied: sum = {0, all-ones exp, 1, zeros}, inv=1.
  - ∞ op finite: ∞ with that sign.
  - Exact-zero result: +0, except (−0)+(−0) gives −0.
- Overflow: biased exponent ≥ all-ones after rounding gives ±∞, ovf=1.
- Underflow: exponent ≤ 0 gives signed zero (flush-to-zero, no flag).
- ovf/inv are registered alongside sum and valid only when out_valid=1.

## Timing
- Latency: 4 clocks from in_valid&in_ready to out_valid for the same pair, when unstalled. Throughput is 1/clock.
- Stall rule: advance = !out_valid || out_ready. All stages shift together on advance, and bubbles are not squeezed. in_ready = advance (combinational from out_ready and out_valid).
- While out_valid=1 and out_ready=0: sum, ovf, inv and out_valid hold stable, and no stage changes.
- Transfer occurs on a cycle where valid&ready; an operand presented with in_ready=0 is not captured and must be held.
- Reset (asynchronous assert, any time including mid-stream): all stage valid bits, out_valid, sum, ovf and inv go to 0. In-flight operations are discarded. in_ready=1 during and after reset.
- Simultaneous out handshake and new input: the new input is accepted the same cycle; no bubble is inserted.

## Test plan
- 1.5 + 2.25: a=0x3FC00000, b=0x40100000, sub=0 → sum=0x40700000 exactly 4 clocks later, ovf=inv=0.
- Infinities:
  - 0x7F800000 + 0x40100000 → 0x7F800000.
  - 0xFF800000 + 0x40100000 → 0xFF800000.
  - 0x7F800000 − 0x7F800000 → 0x7FC00000, inv=1.
- Rounding:
  - 0x3F800000 + 0x33800000 (tie) → 0x3F800000.
  - 0x3F800001 + 0x33800000 → 0x3F800002.
  - 0x3FC00000 − 0x3FC00000 → 0x00000000.
  - 0x80000000 + 0x80000000 → 0x80000000.
- Overflow: 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, ovf=1.
- Back-pressure:
  - Stream 8 back-to-back pairs while holding out_ready=0 for cycles 5–9. Results must come out in order with no loss or duplication. sum must be stable while stalled, and in_ready=0 exactly while out_valid&!out_ready.
- Reset mid-stream: assert rst_n=0 with 3 operations in flight. out_valid and sum must drop to 0 immediately, and no stale result may appear after release. A pair issued after release must return after 4 clocks.

Source files
------------

// File: rtl/float_add_pipe.sv
// float_add_pipe: 4-stage IEEE-754-style adder/subtractor with valid/ready stream, round-to-nearest-even, flush-to-zero, ovf/inv flags
// Ports: clk; rst_n (async, active-low); in_valid/in_ready with operands a, b and sub (1: a-b);
//        out_valid/out_ready with result sum, ovf (finite overflow to infinity), inv (NaN input or inf-inf, sum is qNaN)
module float_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         ovf,
  output logic         inv
);
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [MAN_W-1:0] ZF = '0;
  localparam logic [W-2:0] ZM = '0;
  localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
  typedef struct packed {
    logic v, byp, inv, sx, sy;
    logic [EXP_W-1:0] ex, ey;
    logic [MAN_W:0] mx, my;
    logic [W-1:0] bsum;
  } s1_t;
  typedef struct packed {
    logic v, byp, inv, sx, es;
    logic [EXP_W-1:0] ex;
    logic [MAN_W:0] mx;
    logic [MAN_W+3:0] my;
    logic [W-1:0] bsum;
  } s2_t;
  typedef struct packed {
    logic v, byp, inv, sx;
    logic [EXP_W-1:0] ex;
    logic [MAN_W+4:0] m;
    logic [W-1:0] bsum;
  } s3_t;
  typedef struct packed {
    logic v, ovf, inv;
    logic [W-1:0] sum;
  } o_t;
  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  s3_t s3_d, s3_q;
  o_t o_d, o_q;
  logic adv;
  assign adv = !o_q.v || out_ready;
  assign in_ready = adv;
  assign out_valid = o_q.v;
  assign sum = o_q.sum;
  assign ovf = o_q.ovf;
  assign inv = o_q.inv;
  logic sa, sb, a_z, b_z, a_inf, b_inf, a_nan, b_nan, swap;
  logic [MAN_W:0] ma, mb;
  always_comb begin
    sa = a[W-1];
    sb = b[W-1] ^ sub;
    a_z = a[W-2:MAN_W] == '0;
    b_z = b[W-2:MAN_W] == '0;
    a_inf = a[W-2:MAN_W] == EMAX && a[MAN_W-1:0] == ZF;
    b_inf = b[W-2:MAN_W] == EMAX && b[MAN_W-1:0] == ZF;
    a_nan = a[W-2:MAN_W] == EMAX && a[MAN_W-1:0] != ZF;
    b_nan = b[W-2:MAN_W] == EMAX && b[MAN_W-1:0] != ZF;
    ma = a_z ? '0 : {1'b1, a[MAN_W-1:0]};
    mb = b_z ? '0 : {1'b1, b[MAN_W-1:0]};
    swap = (b_z ? ZM : b[W-2:0]) > (a_z ? ZM : a[W-2:0]);
    s1_d.v = in_valid;
    s1_d.inv = a_nan | b_nan | (a_inf & b_inf & (sa ^ sb));
    s1_d.byp = a_nan | b_nan | a_inf | b_inf | (a_z & b_z);
    s1_d.bsum = s1_d.inv ? QNAN : a_inf ? {sa, EMAX, ZF} : b_inf ? {sb, EMAX, ZF} : {sa & sb, ZM};
    s1_d.sx = swap ? sb : sa;
    s1_d.sy = swap ? sa : sb;
    s1_d.ex = swap ? b[W-2:MAN_W] : a[W-2:MAN_W];
    s1_d.ey = swap ? a[W-2:MAN_W] : b[W-2:MAN_W];
    s1_d.mx = swap ? mb : ma;
    s1_d.my = swap ? ma : mb;
  end
  logic [EXP_W-1:0] d;
  logic [MAN_W+3:0] ext, mask;
  always_comb begin
    d = s1_q.ex - s1_q.ey;
    ext = {s1_q.my, 3'b000};
    mask = ~({(MAN_W+4){1'b1}} << d);
    s2_d.v = s1_q.v;
    s2_d.byp = s1_q.byp;
    s2_d.inv = s1_q.inv;
    s2_d.bsum = s1_q.bsum;
    s2_d.sx = s1_q.sx;
    s2_d.es = s1_q.sx ^ s1_q.sy;
    s2_d.ex = s1_q.ex;
    s2_d.mx = s1_q.mx;
    // bit 0 is sticky: OR of everything shifted past the round bit
    s2_d.my = 32'(d) >= MAN_W + 4 ? {{(MAN_W+3){1'b0}}, |s1_q.my}
                                   : (ext >> d) | {{(MAN_W+3){1'b0}}, |(ext & mask)};
  end
  always_comb begin
    s3_d.v = s2_q.v;
    s3_d.byp = s2_q.byp;
    s3_d.inv = s2_q.inv;
    s3_d.bsum = s2_q.bsum;
    s3_d.sx = s2_q.sx;
    s3_d.ex = s2_q.ex;
    s3_d.m = s2_q.es ? {1'b0, s2_q.mx, 3'b000} - {1'b0, s2_q.my} : {1'b0, s2_q.mx, 3'b000} + {1'b0, s2_q.my};
  end
  logic [MAN_W+3:0] n;
  logic [MAN_W+1:0] rm;
  logic [MAN_W-1:0] frac;
  logic rnd, zr, of;
  int lz, e, e2;
  always_comb begin
    lz = 0;
    for (int i = 0; i <= MAN_W + 3; i++) if (s3_q.m[i]) lz = MAN_W + 3 - i;
    n = s3_q.m[MAN_W+4] ? {s3_q.m[MAN_W+4:2], s3_q.m[1] | s3_q.m[0]} : s3_q.m[MAN_W+3:0] << lz;
    e = s3_q.m[MAN_W+4] ? int'(s3_q.ex) + 1 : int'(s3_q.ex) - lz;
    rnd = n[2] & (n[1] | n[0] | n[3]);
    rm = {1'b0, n[MAN_W+3:3]} + {{(MAN_W+1){1'b0}}, rnd};
    frac = rm[MAN_W+1] ? rm[MAN_W:1] : rm[MAN_W-1:0];
    e2 = rm[MAN_W+1] ? e + 1 : e;
    zr = s3_q.m == '0;
    of = !zr && e2 >= int'(EMAX);
    o_d.v = s3_q.v;
    o_d.inv = s3_q.v & s3_q.byp & s3_q.inv;
    o_d.ovf = s3_q.v & !s3_q.byp & of;
    o_d.sum = s3_q.byp ? s3_q.bsum : zr ? '0 : of ? {s3_q.sx, EMAX, ZF}
            : e2 <= 0 ? {s3_q.sx, ZM} : {s3_q.sx, e2[EXP_W-1:0], frac};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      o_q <= '0;
    end else if (adv) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
      o_q <= o_d;
    end
endmodule

// File: tb/tb_float_add_pipe.sv
// tb_float_add_pipe: directed vectors, back-pressure, mid-stream reset and random stream against an exact-arithmetic model
module tb_float_add_pipe;
  logic clk = 0, rst_n = 0, in_valid = 0, sub = 0, out_ready = 1;
  logic in_ready, out_valid, ovf, inv;
  logic [31:0] a = 0, b = 0, sum;
  int checks = 0, errors = 0, got = 0, sent = 0;
  logic stall_prev = 0;
  logic [31:0] sum_prev = 0;
  typedef logic [33:0] res_t;
  typedef struct packed {
    logic [31:0] a, b;
    logic sub;
    logic [31:0] s;
    logic o, i;
  } vec_t;
  res_t exp_q[$];

  float_add_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .ovf(ovf), .inv(inv)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic res_t ref_add(logic [31:0] x, logic [31:0] y, logic s);
    logic sx, sy, sr;
    logic [7:0] ex, ey;
    logic [22:0] fx, fy;
    logic [299:0] mx, my, mag, q, rem, half, one;
    int p, e, sh;
    sx = x[31]; sy = y[31] ^ s;
    ex = x[30:23]; ey = y[30:23];
    fx = x[22:0]; fy = y[22:0];
    if ((ex == 255 && fx != 0) || (ey == 255 && fy != 0) || (ex == 255 && ey == 255 && sx != sy))
      return {2'b01, 32'h7FC00000};
    if (ex == 255) return {2'b00, sx, 8'hFF, 23'h0};
    if (ey == 255) return {2'b00, sy, 8'hFF, 23'h0};
    if (ex == 0 && ey == 0) return {2'b00, sx & sy, 31'h0};
    one = 1;
    mx = 300'({1'b1, fx});
    my = 300'({1'b1, fy});
    mx = (ex == 0) ? '0 : mx << (ex - 1);
    my = (ey == 0) ? '0 : my << (ey - 1);
    if (sx == sy) begin mag = mx + my; sr = sx; end
    else if (mx >= my) begin mag = mx - my; sr = sx; end
    else begin mag = my - mx; sr = sy; end
    if (mag == 0) return 34'h0;
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    e = p - 22;
    if (p > 23) begin
      sh = p - 23;
      q = mag >> sh;
      rem = mag & ((one << sh) - one);
      half = one << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + one;
      if (q[24]) begin q = q >> 1; e++; end
    end else q = mag << (23 - p);
    if (e >= 255) return {2'b10, sr, 8'hFF, 23'h0};
    if (e <= 0) return {2'b00, sr, 31'h0};
    return {2'b00, sr, 8'(e), q[22:0]};
  endfunction

  function automatic logic [31:0] rand_f(logic [7:0] near, logic use_near);
    logic [31:0] sp [0:6];
    int k, dl, e;
    sp = '{32'h0, 32'h80000000, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h00000001, 32'h7F7FFFFF};
    k = int'($urandom_range(0, 9));
    if (k == 0) return sp[$urandom_range(0, 6)];
    dl = int'($urandom_range(0, 52)) - 26;
    e = use_near ? int'(near) + dl : int'($urandom_range(1, 254));
    e = e < 1 ? 1 : e > 254 ? 254 : e;
    return {1'($urandom_range(0, 1)), 8'(e), 23'($urandom)};
  endfunction

  task automatic tick(output bit acc);
    res_t r;
    @(negedge clk);
    chk("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
    if (stall_prev) begin
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_sum", 64'(sum), 64'(sum_prev));
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL extra_out: got result %h expected none", sum);
      end else begin
        r = exp_q.pop_front();
        chk("sum", 64'(sum), 64'(r[31:0]));
        chk("ovf", 64'(ovf), 64'(r[33]));
        chk("inv", 64'(inv), 64'(r[32]));
        got++;
      end
    end
    stall_prev = out_valid && !out_ready;
    sum_prev = sum;
    acc = in_valid && in_ready;
    if (acc) begin exp_q.push_back(ref_add(a, b, sub)); sent++; end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    bit acc;
    int n;
    in_valid = 0; out_ready = 1; n = 0;
    while (exp_q.size() != 0 && n < 50) begin tick(acc); n++; end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic single(vec_t v);
    int lat;
    a = v.a; b = v.b; sub = v.sub; in_valid = 1; out_ready = 1;
    chk("model", 64'(ref_add(v.a, v.b, v.sub)), 64'({v.o, v.i, v.s}));
    @(negedge clk);
    chk("single_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("latency", 64'(lat), 64'd4);
    @(negedge clk);
    chk("vec_sum", 64'(sum), 64'(v.s));
    chk("vec_ovf", 64'(ovf), 64'(v.o));
    chk("vec_inv", 64'(inv), 64'(v.i));
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t tv [15];
    bit acc;
    int c, n;
    tv = '{
      '{32'h3FC00000, 32'h40100000, 1'b0, 32'h40700000, 1'b0, 1'b0},
      '{32'h7F800000, 32'h40100000, 1'b0, 32'h7F800000, 1'b0, 1'b0},
      '{32'hFF800000, 32'h40100000, 1'b0, 32'hFF800000, 1'b0, 1'b0},
      '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0, 1'b1},
      '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0},
      '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 1'b0, 1'b0},
      '{32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, 1'b0, 1'b0},
      '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b0},
      '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0},
      '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b1},
      '{32'hFF800000, 32'h7F800000, 1'b1, 32'hFF800000, 1'b0, 1'b0},
      '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 1'b0, 1'b0},
      '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0, 1'b0},
      '{32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b0},
      '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 1'b0, 1'b0}
    };
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_inv", 64'(inv), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    foreach (tv[i]) single(tv[i]);

    // 8 back-to-back pairs with the sink stalled in cycles 5-9
    sent = 0; got = 0; stall_prev = 0;
    a = rand_f(8'd0, 1'b0); b = rand_f(a[30:23], 1'b1); sub = 1'($urandom_range(0, 1));
    for (c = 0; c < 30; c++) begin
      in_valid = sent < 8;
      out_ready = !(c >= 5 && c <= 9);
      tick(acc);
      if (acc) begin a = rand_f(8'd0, 1'b0); b = rand_f(a[30:23], 1'b1); sub = 1'($urandom_range(0, 1)); end
    end
    drain();
    chk("bp_sent", 64'(sent), 64'd8);
    chk("bp_got", 64'(got), 64'd8);

    // random stream with random bubbles and back-pressure
    sent = 0; got = 0; in_valid = 0;
    for (c = 0; c < 600; c++) begin
      if (!in_valid || acc) begin
        in_valid = $urandom_range(0, 3) != 0;
        a = rand_f(8'd0, 1'b0);
        b = rand_f(a[30:23], 1'($urandom_range(0, 1)));
        sub = 1'($urandom_range(0, 1));
      end
      out_ready = $urandom_range(0, 3) != 0;
      tick(acc);
    end
    drain();
    chk("rand_count", 64'(got), 64'(sent));

    // reset with a result at the output and three operations in flight
    a = 32'h3F800000; b = 32'h3F800000; sub = 0; in_valid = 1; out_ready = 1;
    repeat (5) @(posedge clk);
    #1 in_valid = 0;
    #1;
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    chk("pre_rst_sum", 64'(sum), 64'h40000000);
    rst_n = 0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_sum", 64'(sum), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    chk("rst_hold_valid", 64'(out_valid), 64'd0);
    @(negedge clk) rst_n = 1;
    n = 0;
    for (c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("stale_results", 64'(n), 64'd0);
    @(posedge clk); #1;
    single(tv[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
